main_memory: RTL



---
 rtl/cache_data_structs.sv | 19 +
 rtl/main_memory_if.sv | 10 +
 rtl/main_mem_array.sv | 47 ++++
 rtl/main_memory.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cache_data_structs.sv
// Shared request/response types for the data-cache <-> main-memory link.
package cache_data_structs;

  localparam int MEM_LINE_W      = 64;
  localparam int MEM_OFFSET_BITS = 3;

  typedef struct packed {
    logic [31:0]           addr;
    logic [MEM_LINE_W-1:0] data;
    logic                  rw;
    logic                  valid;
  } mem_req_type;

  typedef struct packed {
    logic [MEM_LINE_W-1:0] data;
    logic                  ready;
  } mem_res_type;

endpackage

// File: rtl/main_memory_if.sv
// Bundles the mem_req/mem_res pair; the cache is master, main memory is slave.
interface main_memory_if;
  import cache_data_structs::*;

  mem_req_type mem_req;
  mem_res_type mem_res;

  modport master (output mem_req, input mem_res);
  modport slave  (input mem_req, output mem_res);
endinterface

// File: rtl/main_mem_array.sv
// DEPTH x 64 line store: one synchronous write port, one registered read port.
// Kept separate so it can be replaced by an SRAM macro with write-first behaviour.
module main_mem_array
  import cache_data_structs::*;
#(
  parameter  int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [MEM_LINE_W-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [MEM_LINE_W-1:0] rd_data
);

  logic [MEM_LINE_W-1:0] mem [DEPTH];
  logic [MEM_LINE_W-1:0] rd_data_q;
  logic [MEM_LINE_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Write-first: a same-edge read of the line being written returns the new data.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/main_memory.sv
// Fixed-latency main-memory responder for the data cache (one request at a time).
// Optional MAIN_MEMORY_STATS_EN adds saturating rd_count/wr_count commit counters.
module main_memory
  import cache_data_structs::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 1024
) (
  input  logic         clk,
  input  logic         n_rst,
  main_memory_if.slave mem_bus
`ifdef MAIN_MEMORY_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [MEM_LINE_W-1:0] wdata_q, wdata_d;
  logic                  rw_q, rw_d;

  logic                  accept;
  logic [IDX_W-1:0]      req_idx;
  logic                  commit;
  logic [IDX_W-1:0]      commit_idx;
  logic [MEM_LINE_W-1:0] commit_data;
  logic                  commit_rw;
  logic                  wr_en;
  logic [MEM_LINE_W-1:0] rd_data;

  // Offset bits and aliasing upper bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_bus.mem_req.addr[31:MEM_OFFSET_BITS+IDX_W],
                              mem_bus.mem_req.addr[MEM_OFFSET_BITS-1:0]};

  assign req_idx = mem_bus.mem_req.addr[MEM_OFFSET_BITS +: IDX_W];
  assign accept  = mem_bus.mem_req.valid && (state_q != WAIT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          idx_d   = req_idx;
          wdata_d = mem_bus.mem_req.data;
          rw_d    = mem_bus.mem_req.rw;
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The commit happens on the edge that enters DONE; with LATENCY=1 that is
  // the accept edge itself, so the live request is used instead of the latch.
  always_comb begin
    commit      = (state_d == DONE);
    commit_idx  = (LATENCY == 1) ? req_idx              : idx_q;
    commit_data = (LATENCY == 1) ? mem_bus.mem_req.data : wdata_q;
    commit_rw   = (LATENCY == 1) ? mem_bus.mem_req.rw   : rw_q;
    wr_en       = commit && commit_rw;
    mem_bus.mem_res = '{data: rd_data, ready: (state_q == DONE)};
  end

  main_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (wr_en),
    .wr_idx  (commit_idx),
    .wr_data (commit_data),
    .rd_en   (commit),
    .rd_idx  (commit_idx),
    .rd_data (rd_data)
  );

`ifdef MAIN_MEMORY_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (commit && !commit_rw && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
    if (commit && commit_rw && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule
